// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the X-stage multiply/divide sequencer.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10,
        ST_DONE  = 2'b11
    } mds_state_e;

    localparam logic [4:0] ALUOP_MULT = 5'b00110;
    localparam logic [4:0] ALUOP_DIV  = 5'b00111;

    function automatic logic is_multdiv_aluop(input logic [4:0] aluop);
        return (aluop == ALUOP_MULT) || (aluop == ALUOP_DIV);
    endfunction

endpackage

// File: rtl/multdiv_sequencer_timeout_counter.sv
// Watchdog cycle counter for the BUSY phase; flags the last allowed cycle.
module mds_timeout_counter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count_r;

    // Cycle count, held at zero while cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Issues one start pulse to the multdiv unit, stalls the pipeline until the
// unit answers (or the watchdog fires) and presents the result for one cycle.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        x_valid,
    input  logic        x_is_div,
    input  logic        x_flush,
    input  logic [31:0] x_op_a,
    input  logic [31:0] x_op_b,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    input  logic        unit_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] unit_op_a,
    output logic [31:0] unit_op_b,
    output logic        stall,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_valid,
    output logic        busy
);

    mds_state_e  state_r, next_state_s;
    logic        accept_s, capture_s, timeout_s, stall_s;
    logic        cnt_clear_s, cnt_enable_s, expired_s;
    logic        ctrl_mult_r, ctrl_div_r, result_valid_r, busy_r, exception_r;
    logic [31:0] op_a_r, op_b_r, result_r;

    mds_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (cnt_clear_s),
        .enable  (cnt_enable_s),
        .expired (expired_s)
    );

    // Next-state, stall and capture decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        stall_s      = 1'b0;
        cnt_clear_s  = (state_r != ST_BUSY);
        cnt_enable_s = (state_r == ST_BUSY);
        case (state_r)
            ST_IDLE: begin
                if (x_valid && !x_flush) begin
                    stall_s      = 1'b1;
                    accept_s     = 1'b1;
                    next_state_s = ST_START;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (x_flush) begin
                    next_state_s = ST_IDLE;
                end else begin
                    stall_s      = 1'b1;
                    next_state_s = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A squash abandons the operation; ready takes priority over the watchdog.
                if (x_flush) begin
                    next_state_s = ST_IDLE;
                end else if (unit_ready) begin
                    stall_s      = 1'b1;
                    capture_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else if (expired_s) begin
                    stall_s      = 1'b1;
                    timeout_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    stall_s      = 1'b1;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            ctrl_mult_r    <= 1'b0;
            ctrl_div_r     <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            op_a_r         <= 32'h0000_0000;
            op_b_r         <= 32'h0000_0000;
            result_r       <= 32'h0000_0000;
            exception_r    <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            ctrl_mult_r    <= accept_s && !x_is_div;
            ctrl_div_r     <= accept_s && x_is_div;
            result_valid_r <= (next_state_s == ST_DONE);
            busy_r         <= (next_state_s != ST_IDLE);
            if (accept_s) begin
                op_a_r <= x_op_a;
                op_b_r <= x_op_b;
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
            if (capture_s) begin
                result_r    <= unit_result;
                exception_r <= unit_exception;
            end else if (timeout_s) begin
                result_r    <= 32'h0000_0000;
                exception_r <= 1'b1;
            end else begin
                result_r    <= result_r;
                exception_r <= exception_r;
            end
        end
    end

    assign ctrl_MULT    = ctrl_mult_r;
    assign ctrl_DIV     = ctrl_div_r;
    assign unit_op_a    = op_a_r;
    assign unit_op_b    = op_b_r;
    assign stall        = stall_s;
    assign result       = result_r;
    assign exception    = exception_r;
    assign result_valid = result_valid_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer with a latency-programmable unit model.
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0, x_is_div = 1'b0, x_flush = 1'b0;
    logic [31:0] x_op_a = 32'h0, x_op_b = 32'h0;
    logic [31:0] unit_result;
    logic        unit_exception, unit_ready;
    logic        ctrl_MULT, ctrl_DIV, stall, exception, result_valid, busy;
    logic [31:0] unit_op_a, unit_op_b, result;

    int passed = 0;
    int total  = 0;
    int n_mult = 0;
    int n_div  = 0;
    int n_rv   = 0;
    int n_stall = 0;

    int          m_lat   = 1;
    bit          m_never = 1'b0;
    logic        m_active;
    int          m_cnt;
    logic [31:0] m_a, m_b;
    logic        m_div;
    logic [32:0] m_out;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock(clock), .reset(reset),
        .x_valid(x_valid), .x_is_div(x_is_div), .x_flush(x_flush),
        .x_op_a(x_op_a), .x_op_b(x_op_b),
        .unit_result(unit_result), .unit_exception(unit_exception), .unit_ready(unit_ready),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .unit_op_a(unit_op_a), .unit_op_b(unit_op_b),
        .stall(stall), .result(result), .exception(exception),
        .result_valid(result_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    // Arithmetic behaviour of the multdiv unit: {exception, data}.
    function automatic logic [32:0] unit_fn(input logic [31:0] a, input logic [31:0] b, input logic div);
        longint p;
        logic [31:0] q;
        if (!div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            q = p[31:0];
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), q};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Unit model: raises ready m_lat cycles after the start pulse.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            m_active <= 1'b1;
            m_cnt    <= 1;
            m_a      <= unit_op_a;
            m_b      <= unit_op_b;
            m_div    <= ctrl_DIV;
        end else if (m_active) begin
            if (m_cnt >= m_lat) m_active <= 1'b0;
            m_cnt <= m_cnt + 1;
        end
    end

    assign m_out          = unit_fn(m_a, m_b, m_div);
    assign unit_ready     = m_active && !m_never && (m_cnt == m_lat);
    assign unit_result    = m_out[31:0];
    assign unit_exception = m_out[32];

    // Event monitors sampled mid-cycle.
    always @(negedge clock) begin
        if (ctrl_MULT) n_mult++;
        if (ctrl_DIV) n_div++;
        if (result_valid) n_rv++;
        if (stall) n_stall++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One mult/div from x_valid to the DONE cycle; caller is at a negedge.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic div, input int lat, input bit never);
        int eff, stall_cnt, rv_it, m0, d0;
        bit timed_out;
        logic [32:0] exp;
        timed_out = never || (lat > TIMEOUT);
        eff       = timed_out ? TIMEOUT : lat;
        exp       = timed_out ? {1'b1, 32'h0} : unit_fn(a, b, div);
        m_lat = lat; m_never = never;
        x_valid = 1'b1; x_is_div = div; x_op_a = a; x_op_b = b; x_flush = 1'b0;
        m0 = n_mult; d0 = n_div;
        stall_cnt = 0; rv_it = -1;
        for (int it = 0; it < 100; it++) begin
            #1;
            if (stall) stall_cnt++;
            if (it == 0) begin
                chk({tag, " idle_busy"}, busy, 1'b0);
                chk({tag, " idle_pulse"}, {ctrl_MULT, ctrl_DIV}, 2'b00);
                chk({tag, " idle_stall"}, stall, 1'b1);
            end
            if (it == 1) begin
                chk({tag, " pulse"}, {ctrl_MULT, ctrl_DIV}, {!div, div});
                chk({tag, " op_a"}, unit_op_a, a);
                chk({tag, " op_b"}, unit_op_b, b);
            end
            if (result_valid) begin
                rv_it = it;
                break;
            end
            @(negedge clock);
        end
        chk({tag, " rv_cycle"}, rv_it, 2 + eff);
        chk({tag, " stall_cycles"}, stall_cnt, 2 + eff);
        chk({tag, " result"}, result, exp[31:0]);
        chk({tag, " exception"}, exception, exp[32]);
        chk({tag, " done_stall"}, stall, 1'b0);
        chk({tag, " mult_pulses"}, n_mult - m0, {31'h0, !div});
        chk({tag, " div_pulses"}, n_div - d0, {31'h0, div});
    endtask

    // Quiet cycles with no instruction: nothing may happen.
    task automatic idle_check(input string tag, input int n);
        int m0, d0, r0, s0;
        x_valid = 1'b0; x_flush = 1'b0;
        m0 = n_mult; d0 = n_div; r0 = n_rv; s0 = n_stall;
        repeat (n) @(negedge clock);
        #1;
        chk({tag, " quiet_busy"}, busy, 1'b0);
        chk({tag, " quiet_events"}, (n_mult - m0) + (n_div - d0) + (n_rv - r0) + (n_stall - s0), 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        // Reset state.
        repeat (2) @(negedge clock);
        #1;
        chk("reset outputs", {ctrl_MULT, ctrl_DIV, stall, exception, result_valid, busy}, 6'b0);
        chk("reset result", result, 32'h0);
        chk("reset op_a", unit_op_a, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle_check("post_reset", 3);

        // Directed plan cases.
        @(negedge clock);
        run_op("mult7x6", 32'd7, 32'd6, 1'b0, 32, 1'b0);
        idle_check("mult7x6", 2);
        @(negedge clock);
        run_op("div100by0", 32'd100, 32'd0, 1'b1, 5, 1'b0);
        idle_check("div100by0", 2);
        @(negedge clock);
        run_op("timeout", 32'd12, 32'd13, 1'b0, 1, 1'b1);
        idle_check("timeout", 2);
        @(negedge clock);
        run_op("ready_at_limit", 32'd1000, 32'd7, 1'b1, TIMEOUT, 1'b0);
        idle_check("ready_at_limit", 2);
        @(negedge clock);
        run_op("min_latency", 32'hFFFF_FFFE, 32'd3, 1'b0, 1, 1'b0);
        idle_check("min_latency", 2);

        // Back-to-back with x_valid held through DONE.
        @(negedge clock);
        run_op("b2b_first", 32'd3, 32'd3, 1'b0, 4, 1'b0);
        @(negedge clock);
        run_op("b2b_second", 32'd4, 32'd5, 1'b0, 6, 1'b0);
        idle_check("b2b", 2);

        // Flush five cycles into BUSY; the late ready must be ignored.
        @(negedge clock);
        m_lat = 20; m_never = 1'b0;
        x_valid = 1'b1; x_is_div = 1'b0; x_op_a = 32'd9; x_op_b = 32'd9;
        repeat (7) @(negedge clock);
        x_flush = 1'b1;
        #1;
        chk("flush stall_drop", stall, 1'b0);
        chk("flush rv", result_valid, 1'b0);
        @(negedge clock);
        idle_check("flush", 30);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clock);
        m_lat = 30; m_never = 1'b0;
        x_valid = 1'b1; x_is_div = 1'b1; x_op_a = 32'd77; x_op_b = 32'd7;
        repeat (10) @(negedge clock);
        #2;
        x_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midreset outputs", {ctrl_MULT, ctrl_DIV, stall, exception, result_valid, busy}, 6'b0);
        chk("midreset op_b", unit_op_b, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle_check("midreset", 40);

        // Randomised operations.
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if (k[0]) rb = rb >> $urandom_range(0, 28);
            @(negedge clock);
            run_op($sformatf("rand%0d", k), ra, rb, 1'($urandom_range(0, 1)),
                   $urandom_range(1, 45), ($urandom_range(0, 7) == 0));
            idle_check($sformatf("rand%0d", k), 2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Controls the multi-cycle multiply/divide unit on behalf of the execute stage of the 5-stage pipeline.
- Captures operands for a mult/div instruction in X and issues exactly one start pulse to the unit.
- Holds the pipeline (stall) until the unit reports ready, then presents the latched result and exception for one cycle.
- Replaces the ad-hoc in-progress flop in the X stage. Adds a timeout watchdog and flush handling.

Parameters:
- TIMEOUT, 40, maximum cycles spent in BUSY before the operation is aborted with an exception.
- CNT_W, 6, cycle-counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_valid  in  1  instruction in X is a mult or div (opcode ALU, ALUop 00110/00111).
- x_is_div  in  1  1 = div, 0 = mult; sampled with x_valid.
- x_flush  in  1  X-stage instruction is being squashed (branch/jump).
- x_op_a  in  32  operand A, already bypassed.
- x_op_b  in  32  operand B, already bypassed.
- unit_result  in  32  multdiv data_result.
- unit_exception  in  1  multdiv data_exception.
- unit_ready  in  1  multdiv data_resultRDY.
- ctrl_MULT  out  1  one-cycle start pulse, multiply.
- ctrl_DIV  out  1  one-cycle start pulse, divide.
- unit_op_a  out  32  latched operand A to the unit.
- unit_op_b  out  32  latched operand B to the unit.
- stall  out  1  hold PC, F/D, D/X, X/M and M/W.
- result  out  32  latched product/quotient.
- exception  out  1  overflow, divide-by-zero or timeout.
- result_valid  out  1  result/exception valid this cycle; the pipeline advances at its end.
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Ports are named clock and reset.
- Reset values: state=IDLE, counter=0, every output 0, operand and result registers 0. Reset mid-operation aborts immediately. No pulse and no result are produced after reset deasserts.

States:
- IDLE
  - x_valid=1 and x_flush=0: stall=1 combinationally this cycle. Latch x_op_a, x_op_b, x_is_div. Next state START.
  - x_valid=1 and x_flush=1: ignored; stay in IDLE, stall=0.
- START (exactly 1 cycle)
  - ctrl_MULT = ~is_div, ctrl_DIV = is_div, registered outputs; stall=1; counter cleared.
  - unit_ready is ignored in this state. Next state BUSY.
- BUSY
  - stall=1; counter increments each cycle.
  - unit_ready=1: latch unit_result and unit_exception; next state DONE.
  - counter == TIMEOUT-1 with no ready: latch result=0, exception=1; next state DONE.
  - Ready and timeout in the same cycle: ready wins.
- DONE (exactly 1 cycle)
  - stall=0, result_valid=1. Next state IDLE.
  - x_valid in this cycle refers to the same instruction; it must not restart the unit. The FSM returns to IDLE, and the next instruction is seen a cycle later.

Flush and timing rules:
- x_flush in START or BUSY: next state IDLE. stall drops the same cycle, no result_valid, and a late unit_ready is ignored.
- x_flush in DONE: result_valid still 1. The consumer discards it.
- Latency: x_valid at cycle N gives the pulse at N+1, and result_valid at N+2+L, where L is the number of cycles from pulse to unit_ready. Pipeline stall cycles = 2+L.
- stall = (IDLE & x_valid & ~x_flush) | START | BUSY.
- No back-to-back issue: a second mult/div incurs one IDLE cycle after DONE.

Decomposition:
- Shared package:
  - state encoding: IDLE=2'b00, START=2'b01, BUSY=2'b10, DONE=2'b11;
  - mult/div ALUop constants 5'b00110 and 5'b00111.
- One natural sub-module: mds_timeout_counter, a CNT_W-bit counter with clear/enable and an expired flag at TIMEOUT-1. Everything else is flat.

Test Plan:
- mult 7 x 6, unit model ready 32 cycles after pulse -> one ctrl_MULT pulse, stall high 34 cycles, result_valid one cycle with result=42, exception=0.
- div 100 / 0, model asserts unit_exception with ready -> ctrl_DIV single pulse, result_valid with exception=1.
- Model never asserts ready, TIMEOUT=40 -> after 40 BUSY cycles result_valid=1, result=0, exception=1, then IDLE.
- x_flush asserted 5 cycles into BUSY, ready arrives later -> stall drops that cycle, result_valid never asserted, busy=0, no second pulse.
- Two consecutive mults (3x3 then 4x5) with x_valid held through DONE -> exactly two start pulses, results 9 then 20, one IDLE gap between them.
- reset asserted mid-BUSY, asynchronous -> all outputs 0 immediately, no pulse or result_valid after release until a new x_valid.
